mc_controller: RTL and testbench

- Multicycle MIPS control unit that sits directly upstream of the 32-bit ALU.
- A Moore main FSM sequences fetch, decode, execute, memory and writeback over several cycles. It drives all datapath enables and multiplexer selects.
- An internal ALU decoder produces the 3-bit alucontrol consumed by the ALU. The ALU's zero flag is fed back for branch resolution.

---
 rtl/mc_controller.sv | 178 +++++++++++++++++
 tb/tb_mc_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore main FSM plus ALU decoder.
// Outputs are decoded from the current state (plus op/funct/zero where the
// instruction needs them) and gated off while reset is high.
module mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
      S_BNEEX   = 4'd12
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t cur;
   logic   pcwrite, branch_eq, branch_ne;
   logic   irwrite_raw, memwrite_raw, regwrite_raw, illegal_raw;

   assign state = cur;

   // State register and next-state sequencing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur <= S_FETCH;
      end else begin
         case (cur)
            S_FETCH:  cur <= S_DECODE;
            S_DECODE: begin
               case (op)
                  OP_LW, OP_SW: cur <= S_MEMADR;
                  OP_RTYPE:     cur <= S_RTYPEEX;
                  OP_BEQ:       cur <= S_BEQEX;
                  OP_BNE:       cur <= S_BNEEX;
                  OP_ADDI:      cur <= S_ADDIEX;
                  OP_J:         cur <= S_JEX;
                  default:      cur <= S_FETCH;
               endcase
            end
            S_MEMADR:  cur <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   cur <= S_MEMWB;
            S_RTYPEEX: cur <= S_RTYPEWB;
            S_ADDIEX:  cur <= S_ADDIWB;
            default:   cur <= S_FETCH;
         endcase
      end
   end

   // Per-state control decode, including the ALU decoder for R-type.
   always_comb begin
      pcwrite      = 1'b0;
      branch_eq    = 1'b0;
      branch_ne    = 1'b0;
      irwrite_raw  = 1'b0;
      memwrite_raw = 1'b0;
      regwrite_raw = 1'b0;
      illegal_raw  = 1'b0;
      iord         = 1'b0;
      memtoreg     = 1'b0;
      regdst       = 1'b0;
      alusrca      = 1'b0;
      alusrcb      = 2'b00;
      pcsrc        = 2'b00;
      alucontrol   = ALU_ADD;
      case (cur)
         S_FETCH: begin
            irwrite_raw = 1'b1;
            pcwrite     = 1'b1;
            alusrcb     = 2'b01;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J: illegal_raw = 1'b0;
               default: illegal_raw = 1'b1;
            endcase
         end
         S_MEMADR, S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWR: begin
            iord         = 1'b1;
            memwrite_raw = 1'b1;
         end
         S_MEMWB: begin
            regwrite_raw = 1'b1;
            memtoreg     = 1'b1;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            case (funct)
               6'b100000: alucontrol = ALU_ADD;
               6'b100010: alucontrol = ALU_SUB;
               6'b100100: alucontrol = ALU_AND;
               6'b100101: alucontrol = ALU_OR;
               6'b101010: alucontrol = ALU_SLT;
               default: begin
                  alucontrol  = ALU_ADD;
                  illegal_raw = 1'b1;
               end
            endcase
         end
         S_RTYPEWB: begin
            regdst       = 1'b1;
            regwrite_raw = 1'b1;
         end
         S_ADDIWB: regwrite_raw = 1'b1;
         S_BEQEX: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = 2'b01;
            branch_eq  = 1'b1;
         end
         S_BNEEX: begin
            alusrca    = 1'b1;
            alucontrol = ALU_SUB;
            pcsrc      = 2'b01;
            branch_ne  = 1'b1;
         end
         S_JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset overrides the decoded enables so nothing is written while it is held.
   always_comb begin
      pcen     = ~reset & (pcwrite | (branch_eq & zero) | (branch_ne & ~zero));
      irwrite  = ~reset & irwrite_raw;
      memwrite = ~reset & memwrite_raw;
      regwrite = ~reset & regwrite_raw;
      illegal  = ~reset & illegal_raw;
   end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each instruction pushes its expected
// per-cycle state and control word, then the queue is drained cycle by cycle.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero;
   logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [5:0] op;
      logic [5:0] funct;
      logic       z;
      logic [3:0] st;
      logic [15:0] ctl;
   } exp_t;

   exp_t sb[$];

   logic [15:0] ctl_obs;
   assign ctl_obs = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
                     alusrcb, pcsrc, alucontrol, illegal};

   mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
      .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal),
      .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Control word: pcen irw memw regw iord m2r rdst asa | asb | pcs | alu | ill
   function automatic logic [15:0] cv(input logic pc, input logic irw, input logic mw,
                                      input logic rw, input logic io, input logic m2r,
                                      input logic rd, input logic asa, input logic [1:0] asb,
                                      input logic [1:0] pcs, input logic [2:0] alu,
                                      input logic ill);
      return {pc, irw, mw, rw, io, m2r, rd, asa, asb, pcs, alu, ill};
   endfunction

   task automatic push(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic [3:0] st, input logic [15:0] c);
      exp_t e;
      e.tag = tag; e.op = o; e.funct = f; e.z = z; e.st = st; e.ctl = c;
      sb.push_back(e);
   endtask

   task automatic push_fd(input string tag, input logic [5:0] o, input logic [5:0] f);
      push({tag, "_fetch"},  o, f, 1'b0, 4'd0, cv(1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
      push({tag, "_decode"}, o, f, 1'b0, 4'd1, cv(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0));
   endtask

   // Drain the scoreboard: drive stimulus after a rising edge, compare at the falling edge.
   task automatic run_sb();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         op = e.op; funct = e.funct; zero = e.z;
         @(negedge clk);
         checks++;
         if ({state, ctl_obs} !== {e.st, e.ctl}) begin
            errors++;
            $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                     e.tag, state, ctl_obs, e.st, e.ctl);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      checks++;
      if ({state, pcen, irwrite, memwrite, regwrite, illegal} !== 9'd0) begin
         errors++;
         $display("FAIL %s: got state=%0d pcen=%b irw=%b memw=%b regw=%b ill=%b, expected all 0",
                  tag, state, pcen, irwrite, memwrite, regwrite, illegal);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; op = '0; funct = 6'h20; zero = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset_initial");
      @(posedge clk); #1;
      reset = 1'b0;
      push_fd("rst_r", 6'b000000, 6'h20);
      run_sb();
      // now in RTYPEEX: abort it with reset for three cycles
      reset = 1'b1;
      #1;
      check_reset_vals("reset_mid_rtypeex");
      repeat (3) begin
         @(negedge clk);
         check_reset_vals("reset_held");
      end
      @(posedge clk); #1;
      reset = 1'b0;
      push_fd("rst_after", 6'b000000, 6'h20);
      push("rst_after_ex", 6'b000000, 6'h20, 0, 4'd6, cv(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0));
      push("rst_after_wb", 6'b000000, 6'h20, 0, 4'd7, cv(0,0,0,1,0,0,1,0,2'b00,2'b00,3'b010,0));
      run_sb();
   endtask

   task automatic push_lw();
      push_fd("lw", 6'b100011, 6'h00);
      push("lw_memadr", 6'b100011, 0, 0, 4'd2, cv(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0));
      push("lw_memrd",  6'b100011, 0, 0, 4'd3, cv(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b010,0));
      push("lw_memwb",  6'b100011, 0, 0, 4'd4, cv(0,0,0,1,0,1,0,0,2'b00,2'b00,3'b010,0));
   endtask

   task automatic push_sw();
      push_fd("sw", 6'b101011, 6'h00);
      push("sw_memadr", 6'b101011, 0, 0, 4'd2, cv(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0));
      push("sw_memwr",  6'b101011, 0, 0, 4'd5, cv(0,0,1,0,1,0,0,0,2'b00,2'b00,3'b010,0));
   endtask

   task automatic push_addi();
      push_fd("addi", 6'b001000, 6'h00);
      push("addi_ex", 6'b001000, 0, 0, 4'd9,  cv(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0));
      push("addi_wb", 6'b001000, 0, 0, 4'd10, cv(0,0,0,1,0,0,0,0,2'b00,2'b00,3'b010,0));
   endtask

   task automatic push_j();
      push_fd("j", 6'b000010, 6'h00);
      push("j_ex", 6'b000010, 0, 0, 4'd11, cv(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0));
   endtask

   task automatic test_lw();
      push_lw();
      run_sb();
   endtask

   task automatic test_sw_addi();
      push_sw();
      push_addi();
      run_sb();
   endtask

   task automatic test_rtype();
      logic [5:0] f_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      logic [2:0] a_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
      for (int i = 0; i < 5; i++) begin
         push_fd("rtype", 6'b000000, f_tab[i]);
         push($sformatf("rtype_ex_f%02h", f_tab[i]), 6'b000000, f_tab[i], 0, 4'd6,
              cv(0,0,0,0,0,0,0,1,2'b00,2'b00,a_tab[i],0));
         push($sformatf("rtype_wb_f%02h", f_tab[i]), 6'b000000, f_tab[i], 0, 4'd7,
              cv(0,0,0,1,0,0,1,0,2'b00,2'b00,3'b010,0));
      end
      run_sb();
   endtask

   task automatic test_branch();
      push_fd("beq_z1", 6'b000100, 0);
      push("beq_ex_z1", 6'b000100, 0, 1, 4'd8,  cv(1,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0));
      push_fd("beq_z0", 6'b000100, 0);
      push("beq_ex_z0", 6'b000100, 0, 0, 4'd8,  cv(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0));
      push_fd("bne_z0", 6'b000101, 0);
      push("bne_ex_z0", 6'b000101, 0, 0, 4'd12, cv(1,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0));
      push_fd("bne_z1", 6'b000101, 0);
      push("bne_ex_z1", 6'b000101, 0, 1, 4'd12, cv(0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0));
      run_sb();
   endtask

   task automatic test_jump();
      push_j();
      push_fd("after_j", 6'b000010, 0);
      push("after_j_ex", 6'b000010, 0, 0, 4'd11, cv(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,0));
      run_sb();
   endtask

   task automatic test_illegal();
      push("ill_op_fetch", 6'b111111, 0, 0, 4'd0, cv(1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
      push("ill_op_decode", 6'b111111, 0, 0, 4'd1, cv(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,1));
      push_fd("ill_funct", 6'b000000, 6'b000000);
      push("ill_funct_ex", 6'b000000, 6'b000000, 0, 4'd6, cv(0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,1));
      push("ill_funct_wb", 6'b000000, 6'b000000, 0, 4'd7, cv(0,0,0,1,0,0,1,0,2'b00,2'b00,3'b010,0));
      run_sb();
   endtask

   task automatic test_back_to_back();
      push_sw();
      push_j();
      push_lw();
      push_addi();
      push("b2b_final_fetch", 6'b001000, 0, 0, 4'd0, cv(1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0));
      run_sb();
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_addi();
      test_rtype();
      test_branch();
      test_jump();
      test_illegal();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
